// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the instruction/data memory port arbiter.
// Owner codes tag which requester the in-flight RAM read belongs to.
package mem_pkg;

  localparam logic [1:0] OWNER_NONE  = 2'd0;
  localparam logic [1:0] OWNER_FETCH = 2'd1;
  localparam logic [1:0] OWNER_LOAD  = 2'd2;

  localparam int STARVE_CNT_W = 4;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline's fetch/load-store ports, the arbiter and the RAM.
// Handshake: a requester holds req and payload until gnt (same-cycle, combinational); rvalid follows a read grant by exactly one cycle.
interface mem_port_arbiter_if #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 9
);
  import mem_pkg::*;

  localparam int BE_W = be_width(RAM_WIDTH);

  logic                 if_req;
  logic [RAM_DEPTH-1:0] if_addr;
  logic                 if_gnt;
  logic                 if_rvalid;
  logic [RAM_WIDTH-1:0] if_rdata;

  logic                 d_req;
  logic                 d_we;
  logic [BE_W-1:0]      d_be;
  logic [RAM_DEPTH-1:0] d_addr;
  logic [RAM_WIDTH-1:0] d_wdata;
  logic                 d_gnt;
  logic                 d_rvalid;
  logic [RAM_WIDTH-1:0] d_rdata;

  logic                 mem_en;
  logic                 mem_we;
  logic [BE_W-1:0]      mem_be;
  logic [RAM_DEPTH-1:0] mem_addr;
  logic [RAM_WIDTH-1:0] mem_wdata;
  logic [RAM_WIDTH-1:0] mem_rdata;

  // Environment side: pipeline requesters plus the RAM's read data.
  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store.
// Data wins by default; fetch is forced through after STARVE_LIMIT consecutive losses.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int RAM_WIDTH    = 32,
  parameter int RAM_DEPTH    = 9,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_port_arbiter_if.slave       bus,
  output logic [1:0]              o_dbg_rsp_owner,
  output logic [STARVE_CNT_W-1:0] o_dbg_starve_cnt
);

  localparam int BE_W = be_width(RAM_WIDTH);
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [1:0]              r_rsp_owner;
  logic [1:0]              w_owner_nxt;
  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  logic [STARVE_CNT_W-1:0] w_starve_nxt;
  logic                    w_fetch_forced;
  logic                    w_if_gnt;
  logic                    w_d_gnt;
  logic [RAM_DEPTH-1:0]    w_mem_addr;
  logic [RAM_WIDTH-1:0]    w_mem_wdata;
  logic [BE_W-1:0]         w_mem_be;

  // Grants are gated by reset so nothing reaches the RAM while held in reset.
  assign w_fetch_forced = (r_starve_cnt == LIMIT);
  assign w_if_gnt = reset & bus.if_req & (~bus.d_req | w_fetch_forced);
  assign w_d_gnt  = reset & bus.d_req  & ~(bus.if_req & w_fetch_forced);

  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_be    = '1;
    if (w_d_gnt) begin
      w_mem_addr  = bus.d_addr;
      w_mem_wdata = bus.d_wdata;
      w_mem_be    = bus.d_be;
    end else if (w_if_gnt) begin
      w_mem_addr  = bus.if_addr;
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.mem_en    = w_if_gnt | w_d_gnt;
  assign bus.mem_we    = w_d_gnt & bus.d_we;
  assign bus.mem_be    = w_mem_be;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

  always_comb begin
    w_owner_nxt = OWNER_NONE;
    if (w_if_gnt)                 w_owner_nxt = OWNER_FETCH;
    else if (w_d_gnt && !bus.d_we) w_owner_nxt = OWNER_LOAD;
  end

  // Counts consecutive fetch losses; saturates so the forced win stays asserted.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_if_gnt || !bus.if_req)
      w_starve_nxt = '0;
    else if (w_d_gnt && (r_starve_cnt != LIMIT))
      w_starve_nxt = r_starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_owner  <= OWNER_NONE;
      r_starve_cnt <= '0;
    end else begin
      r_rsp_owner  <= w_owner_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // The non-owner sees zero so stale RAM output never leaks to the wrong port.
  assign bus.if_rvalid = (r_rsp_owner == OWNER_FETCH);
  assign bus.d_rvalid  = (r_rsp_owner == OWNER_LOAD);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : '0;

  assign o_dbg_rsp_owner  = r_rsp_owner;
  assign o_dbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port RAM.
// Program words are 32'hC0DE_0000 | address until overwritten by stores.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int W = 32;
  localparam int D = 9;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_owner;
  logic [3:0] dbg_starve;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter_if #(.RAM_WIDTH(W), .RAM_DEPTH(D)) bus ();

  mem_port_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D), .STARVE_LIMIT(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .o_dbg_rsp_owner  (dbg_owner),
    .o_dbg_starve_cnt (dbg_starve)
  );

  // clock
  always #5 clk = ~clk;

  // RAM model: registered read, byte-enabled write.
  logic [W-1:0] ram [0:(1<<D)-1];
  logic [W-1:0] ram_rdata = '0;
  logic         ram_loaded = 1'b0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < (1 << D); i++) ram[i] <= 32'hC0DE_0000 | W'(i);
      ram_loaded <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < W/8; b++)
          if (bus.mem_be[b]) ram[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end else begin
        ram_rdata <= ram[bus.mem_addr];
      end
    end
  end

  assign bus.mem_rdata = ram_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ifr, input logic [D-1:0] ifa, input logic dr,
                       input logic dwe, input logic [3:0] dbe, input logic [D-1:0] da,
                       input logic [W-1:0] dwd);
    @(negedge clk);
    bus.if_req  = ifr;
    bus.if_addr = ifa;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_be    = dbe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] fetch_wins;

  initial begin
    reset = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 9'd1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 9'd5; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_if_gnt", bus.if_gnt, 0);
    check("rst_d_gnt", bus.d_gnt, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_if_rvalid", bus.if_rvalid, 0);
    check("rst_d_rvalid", bus.d_rvalid, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    check("rst_owner", dbg_owner, OWNER_NONE);
    check("rst_starve", dbg_starve, 0);

    // release: data wins the first cycle, loading program word 5
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_d_gnt", bus.d_gnt, 1);
    check("rel_if_gnt", bus.if_gnt, 0);
    check("rel_mem_addr", bus.mem_addr, 5);
    check("rel_mem_we", bus.mem_we, 0);
    next_cycle();
    check("rel_d_rvalid", bus.d_rvalid, 1);
    check("rel_d_rdata", bus.d_rdata, 32'hC0DE_0005);
    check("rel_starve", dbg_starve, 1);

    // fetch only, addresses 0..4 back to back
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, D'(i), 1'b0, 1'b0, 4'h0, 9'd0, '0);
      check("fe_if_gnt", bus.if_gnt, 1);
      check("fe_d_gnt", bus.d_gnt, 0);
      check("fe_mem_addr", bus.mem_addr, 64'(i));
      check("fe_mem_be", bus.mem_be, 4'hF);
      next_cycle();
      check("fe_if_rvalid", bus.if_rvalid, 1);
      check("fe_if_rdata", bus.if_rdata, 32'hC0DE_0000 | 32'(i));
      check("fe_d_rvalid", bus.d_rvalid, 0);
    end

    // full store then load
    drive(1'b0, 9'd0, 1'b1, 1'b1, 4'hF, 9'd3, 32'hDEAD_BEEF);
    check("st_d_gnt", bus.d_gnt, 1);
    check("st_mem_we", bus.mem_we, 1);
    check("st_mem_be", bus.mem_be, 4'hF);
    check("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    check("st_d_rvalid", bus.d_rvalid, 0);
    check("st_if_rvalid", bus.if_rvalid, 0);
    drive(1'b0, 9'd0, 1'b1, 1'b0, 4'hF, 9'd3, '0);
    check("ld_d_gnt", bus.d_gnt, 1);
    check("ld_d_rvalid_early", bus.d_rvalid, 0);
    next_cycle();
    check("ld_d_rvalid", bus.d_rvalid, 1);
    check("ld_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    check("ld_if_rvalid", bus.if_rvalid, 0);

    // partial store over zero
    drive(1'b0, 9'd0, 1'b1, 1'b1, 4'hF, 9'd3, 32'h0);
    next_cycle();
    drive(1'b0, 9'd0, 1'b1, 1'b1, 4'b0011, 9'd3, 32'hDEAD_BEEF);
    check("pst_mem_be", bus.mem_be, 4'b0011);
    next_cycle();
    drive(1'b0, 9'd0, 1'b1, 1'b0, 4'hF, 9'd3, '0);
    next_cycle();
    check("pld_d_rvalid", bus.d_rvalid, 1);
    check("pld_d_rdata", bus.d_rdata, 32'h0000_BEEF);

    // idle: bus quiet, non-owner data masked even though RAM output is non-zero
    drive(1'b0, 9'd7, 1'b0, 1'b1, 4'h5, 9'd9, 32'h1234_5678);
    check("idle_mem_en", bus.mem_en, 0);
    check("idle_mem_we", bus.mem_we, 0);
    check("idle_mem_addr", bus.mem_addr, 0);
    check("idle_mem_wdata", bus.mem_wdata, 0);
    check("idle_mem_be", bus.mem_be, 4'hF);
    next_cycle();
    check("idle_d_rvalid", bus.d_rvalid, 0);
    check("idle_d_rdata", bus.d_rdata, 0);
    check("idle_if_rdata", bus.if_rdata, 0);

    // starvation: both requesting -> D,D,D,F,D,D,D,F
    fetch_wins = 8'b1000_1000;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 9'd8, 1'b1, 1'b0, 4'hF, 9'd7, '0);
      check("sv_starve", dbg_starve, 64'(c % 4));
      check("sv_if_gnt", bus.if_gnt, fetch_wins[c]);
      check("sv_d_gnt", bus.d_gnt, !fetch_wins[c]);
      next_cycle();
      check("sv_if_rvalid", bus.if_rvalid, fetch_wins[c]);
      check("sv_d_rvalid", bus.d_rvalid, !fetch_wins[c]);
      check("sv_rdata", bus.if_rdata | bus.d_rdata,
            fetch_wins[c] ? 32'hC0DE_0008 : 32'hC0DE_0007);
    end
    check("sv_starve_end", dbg_starve, 0);

    // reset mid-flight: load granted, reset lands before its response cycle ends
    drive(1'b0, 9'd0, 1'b1, 1'b0, 4'hF, 9'd3, '0);
    check("mf_d_gnt", bus.d_gnt, 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mf_d_rvalid_rst", bus.d_rvalid, 0);
    check("mf_owner_rst", dbg_owner, OWNER_NONE);
    drive(1'b0, 9'd0, 1'b0, 1'b0, 4'hF, 9'd0, '0);
    reset = 1'b1;
    next_cycle();
    check("mf_d_rvalid_rel", bus.d_rvalid, 0);
    check("mf_owner_rel", dbg_owner, OWNER_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
